// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the architectural PC, issues one Wishbone
// classic read per instruction and presents {pc, inst, valid} to decode.
// Redirects that land while a read is in flight mark the read as stale so
// its data is dropped when the ack finally arrives; the bus cycle itself is
// always allowed to complete.
module if_fetch_stage #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] PC_ADDR = 32'h8000_0000
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [ADDR_WIDTH-1:0]     pc_next_i,
  input  logic                      branch_i,
  input  logic                      stall_i,
  output logic [ADDR_WIDTH-1:0]     pc_o,
  output logic                      wb_cyc_o,
  output logic                      wb_stb_o,
  output logic                      wb_we_o,
  output logic [DATA_WIDTH/8-1:0]   wb_sel_o,
  output logic [ADDR_WIDTH-1:0]     wb_adr_o,
  input  logic [DATA_WIDTH-1:0]     wb_dat_i,
  input  logic                      wb_ack_i,
  output logic [ADDR_WIDTH-1:0]     if_pc_o,
  output logic [DATA_WIDTH-1:0]     if_inst_o,
  output logic                      if_valid_o
);

  localparam int SEL_WIDTH = DATA_WIDTH / 8;

  // addi x0, x0, 0 -- presented while nothing useful has been fetched yet
  localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h0000_0013);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] FETCH = 1'b1;

  logic [0:0]            state_reg;
  logic [0:0]            state_next;
  logic                  flush_pending_reg;
  logic                  flush_pending_next;
  logic [ADDR_WIDTH-1:0] pc_next;
  logic                  cyc_next;
  logic                  stb_next;
  logic [SEL_WIDTH-1:0]  sel_next;
  logic [ADDR_WIDTH-1:0] adr_next;
  logic [ADDR_WIDTH-1:0] if_pc_next;
  logic [DATA_WIDTH-1:0] if_inst_next;
  logic                  if_valid_next;
  logic                  slot_consumed;
  logic                  slot_free;

  // The presented instruction leaves the slot whenever decode is not stalling.
  assign slot_consumed = if_valid_o && !stall_i;
  // A new fetch may only launch into an empty or draining slot, so the slot
  // is guaranteed free by the time the ack returns.
  assign slot_free     = !if_valid_o || !stall_i;

  // Instruction fetches are read-only.
  assign wb_we_o = 1'b0;

  // Next-state and next-output selection for the two-state fetch controller.
  always_comb begin
    state_next         = state_reg;
    flush_pending_next = flush_pending_reg;
    pc_next            = pc_o;
    cyc_next           = wb_cyc_o;
    stb_next           = wb_stb_o;
    sel_next           = wb_sel_o;
    adr_next           = wb_adr_o;
    if_pc_next         = if_pc_o;
    if_inst_next       = if_inst_o;
    if_valid_next      = if_valid_o;

    case (state_reg)
      IDLE: begin
        if (branch_i) begin
          // Redirect first; the fetch from the new PC starts next cycle.
          pc_next       = pc_next_i;
          if_valid_next = 1'b0;
        end else if (slot_free) begin
          cyc_next   = 1'b1;
          stb_next   = 1'b1;
          sel_next   = '1;
          adr_next   = pc_o;
          state_next = FETCH;
          if (slot_consumed) begin
            if_valid_next = 1'b0;
          end
        end
      end

      FETCH: begin
        if (wb_ack_i) begin
          cyc_next           = 1'b0;
          stb_next           = 1'b0;
          sel_next           = '0;
          state_next         = IDLE;
          flush_pending_next = 1'b0;
          if (flush_pending_reg || branch_i) begin
            // Data belongs to a path that was redirected away from.
            if_valid_next = 1'b0;
            if (branch_i) begin
              pc_next = pc_next_i;
            end
          end else begin
            if_inst_next  = wb_dat_i;
            if_pc_next    = wb_adr_o;
            if_valid_next = 1'b1;
            pc_next       = pc_next_i;
          end
        end else if (branch_i) begin
          // Keep the bus cycle running but remember to drop its data.
          pc_next            = pc_next_i;
          flush_pending_next = 1'b1;
          if_valid_next      = 1'b0;
        end else if (slot_consumed) begin
          if_valid_next = 1'b0;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, PC, bus and output-slot registers; reset overrides every input.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg         <= IDLE;
      flush_pending_reg <= 1'b0;
      pc_o              <= PC_ADDR;
      wb_cyc_o          <= 1'b0;
      wb_stb_o          <= 1'b0;
      wb_sel_o          <= '0;
      wb_adr_o          <= '0;
      if_pc_o           <= '0;
      if_inst_o         <= NOP;
      if_valid_o        <= 1'b0;
    end else begin
      state_reg         <= state_next;
      flush_pending_reg <= flush_pending_next;
      pc_o              <= pc_next;
      wb_cyc_o          <= cyc_next;
      wb_stb_o          <= stb_next;
      wb_sel_o          <= sel_next;
      wb_adr_o          <= adr_next;
      if_pc_o           <= if_pc_next;
      if_inst_o         <= if_inst_next;
      if_valid_o        <= if_valid_next;
    end
  end

endmodule
